// File: rtl/button_debouncer_pkg.sv
// Shared types and sizing helpers for the multi-channel pushbutton conditioner.
// No datapath logic lives here; channels and top import it.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE   = 2'd0,
    BTN_HELD   = 2'd1,
    BTN_REPEAT = 2'd2
  } btn_state_t;

  localparam int SYNC_STAGES = 2;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button: 2-flop sync, SAMPLES-deep agreement filter, press/hold/repeat FSM.
// Pulses land the clock after the shared tick; no backpressure, outputs are fire-and-forget.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int SAMPLES      = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int LONG_TICKS   = 200
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  input  logic button_raw,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_press
);

  localparam int HOLD_MAX = max_of(REPEAT_DELAY, LONG_TICKS);
  localparam int HOLD_W   = cnt_width(HOLD_MAX);
  localparam int REP_W    = cnt_width(REPEAT_RATE);

  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] DELAY_C  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] LONG_C   = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  RATE_C   = REP_W'(REPEAT_RATE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SAMPLES-1:0]     shift_q;
  logic [SAMPLES-1:0]     shift_nxt;
  logic [HOLD_W-1:0]      hold_q;
  logic [HOLD_W-1:0]      hold_nxt;
  logic [REP_W-1:0]       rep_q;
  logic [REP_W-1:0]       rep_nxt;
  logic                   all_ones;
  logic                   all_zeros;
  btn_state_t             state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
    end
  end

  // Decisions look at the shift value as it will be after this tick.
  assign shift_nxt = {shift_q[SAMPLES-2:0], sync_q[SYNC_STAGES-1]};
  assign all_ones  = &shift_nxt;
  assign all_zeros = ~|shift_nxt;
  assign hold_nxt  = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
  assign rep_nxt   = rep_q + REP_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q       <= '0;
      hold_q        <= '0;
      rep_q         <= '0;
      state         <= BTN_IDLE;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (tick) begin
        shift_q <= shift_nxt;
        case (state)
          BTN_IDLE: begin
            if (all_ones) begin
              state       <= BTN_HELD;
              level       <= 1'b1;
              press_pulse <= 1'b1;
              hold_q      <= '0;
              rep_q       <= '0;
            end
          end
          BTN_HELD, BTN_REPEAT: begin
            // Release wins over any repeat/long event landing on the same tick.
            if (all_zeros) begin
              state         <= BTN_IDLE;
              level         <= 1'b0;
              release_pulse <= 1'b1;
              long_press    <= 1'b0;
              hold_q        <= '0;
              rep_q         <= '0;
            end else begin
              hold_q <= hold_nxt;
              if (hold_nxt >= LONG_C) begin
                long_press <= 1'b1;
              end
              if (state == BTN_HELD) begin
                if (repeat_en && (hold_nxt >= DELAY_C)) begin
                  state        <= BTN_REPEAT;
                  repeat_pulse <= 1'b1;
                  rep_q        <= '0;
                end
              end else if (rep_nxt == RATE_C) begin
                // Cadence keeps running while disabled so re-enable resumes in phase.
                repeat_pulse <= repeat_en;
                rep_q        <= '0;
              end else begin
                rep_q <= rep_nxt;
              end
            end
          end
          default: begin
            state <= BTN_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// NUM-channel pushbutton conditioner: shared sample prescaler feeding one debounce_channel per input.
// Press latency 2 sync clocks + up to SAMPLES*2**DIV_BITS clocks + 1; no backpressure.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int NUM          = 4,
  parameter int DIV_BITS     = 20,
  parameter int SAMPLES      = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int LONG_TICKS   = 200
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [NUM-1:0] buttons_in,
  input  logic [NUM-1:0] repeat_en,
  output logic [NUM-1:0] buttons_out,
  output logic [NUM-1:0] press_pulse,
  output logic [NUM-1:0] release_pulse,
  output logic [NUM-1:0] repeat_pulse,
  output logic [NUM-1:0] long_press
);

  logic [DIV_BITS-1:0] presc_q;
  logic                tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + DIV_BITS'(1);
    end
  end

  assign tick = &presc_q;

  for (genvar i = 0; i < NUM; i++) begin : g_ch
    debounce_channel #(
      .SAMPLES      (SAMPLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .LONG_TICKS   (LONG_TICKS)
    ) u_ch (
      .clock         (clock),
      .reset_n       (reset_n),
      .tick          (tick),
      .button_raw    (buttons_in[i]),
      .repeat_en     (repeat_en[i]),
      .level         (buttons_out[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .long_press    (long_press[i])
    );
  end

endmodule
